// File: rtl/modbus_tx_framer.sv
// -----------------------------------------------------------------------------
// modbus_tx_framer
//   Frames Modbus RTU transmissions onto a shared RS-485 bus. A byte is only
//   released to the UART after the bus has been silent for 3.5 character
//   times (T35). Bytes of one frame must follow each other within 1.5
//   character times (T15), otherwise the frame is aborted. The RS-485 driver
//   is enabled for the whole frame without gaps.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  serial line bit rate
//
// Ports
//   clk_in            system clock, all logic on its rising edge
//   rst_in            synchronous active-high reset
//   tx_data_in        frame byte offered by upstream
//   tx_valid_in       tx_data_in / tx_last_in valid
//   tx_last_in        offered byte is the last of the frame
//   tx_ready_out      byte accepted when tx_valid_in & tx_ready_out
//   rx_done_in        one-cycle pulse per byte seen on the shared bus
//   uart_tx_data_out  byte for the UART transmitter (held until next load)
//   uart_tx_en_out    one-cycle start pulse to the UART transmitter
//   uart_tx_done_in   one-cycle pulse when the UART finished the stop bit
//   rs485_de_out      RS-485 driver enable
//   frame_done_out    one-cycle pulse, frame sent completely
//   frame_err_out     one-cycle pulse, frame aborted on inter-character timeout
// -----------------------------------------------------------------------------
module modbus_tx_framer #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] tx_data_in,
  input  logic       tx_valid_in,
  input  logic       tx_last_in,
  output logic       tx_ready_out,
  input  logic       rx_done_in,
  output logic [7:0] uart_tx_data_out,
  output logic       uart_tx_en_out,
  input  logic       uart_tx_done_in,
  output logic       rs485_de_out,
  output logic       frame_done_out,
  output logic       frame_err_out
);

  // Above 19200 baud the gaps are fixed times (1.75 ms / 0.75 ms); below,
  // they scale with the character time (11 bits per character).
  // 64-bit arithmetic keeps CLK_FREQ*385 from overflowing.
  localparam longint T35_L = (BAUD_RATE > 19200)
      ? (64'(CLK_FREQ) * 64'd1750) / 64'd1000000
      : (64'(CLK_FREQ) * 64'd385) / (64'd10 * 64'(BAUD_RATE));
  localparam longint T15_L = (BAUD_RATE > 19200)
      ? (64'(CLK_FREQ) * 64'd750) / 64'd1000000
      : (64'(CLK_FREQ) * 64'd165) / (64'd10 * 64'(BAUD_RATE));
  localparam int T35 = int'(T35_L);
  localparam int T15 = int'(T15_L);
  localparam int CW  = $clog2(T35 + 1);

  localparam logic [CW-1:0] T35_C  = CW'(T35);
  localparam logic [CW-1:0] T15_C  = CW'(T15);
  localparam logic [CW-1:0] ZERO_C = CW'(0);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [2:0] {
    S_QUIET     = 3'd0,
    S_IDLE      = 3'd1,
    S_LOAD      = 3'd2,
    S_BYTE_WAIT = 3'd3,
    S_NEXT      = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] count_r, count_s;
  logic [CW-1:0] count_inc_s;
  logic [7:0]    data_r, data_s;
  logic          last_r, last_s;
  logic          done_r, done_s;
  logic          err_r, err_s;

  // Saturating increment of the shared silence / gap counter.
  always_comb begin
    if (count_r == T35_C) begin
      count_inc_s = count_r;
    end else begin
      count_inc_s = count_r + ONE_C;
    end
  end

  // State register together with the byte buffer and the end-of-frame pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= S_QUIET;
      count_r <= ZERO_C;
      data_r  <= 8'd0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      data_r  <= data_s;
      last_r  <= last_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    data_s  = data_r;
    last_s  = last_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      S_QUIET: begin
        // A byte on the bus restarts silence in the cycle it arrives, so the
        // following cycle already counts as one quiet cycle.
        if (rx_done_in) begin
          count_s = ONE_C;
        end else begin
          count_s = count_inc_s;
        end
        if (count_s == T35_C) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_QUIET;
        end
      end
      S_IDLE: begin
        // Bus activity wins over a same-cycle offer; ready is held low then.
        if (rx_done_in) begin
          state_s = S_QUIET;
          count_s = ZERO_C;
        end else if (tx_valid_in) begin
          state_s = S_LOAD;
          count_s = ZERO_C;
          data_s  = tx_data_in;
          last_s  = tx_last_in;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        state_s = S_BYTE_WAIT;
      end
      S_BYTE_WAIT: begin
        if (uart_tx_done_in) begin
          count_s = ZERO_C;
          if (last_r) begin
            state_s = S_QUIET;
            done_s  = 1'b1;
          end else begin
            state_s = S_NEXT;
          end
        end else begin
          state_s = S_BYTE_WAIT;
        end
      end
      S_NEXT: begin
        // A byte offered in the cycle the gap would expire is still taken.
        if (tx_valid_in) begin
          state_s = S_LOAD;
          count_s = ZERO_C;
          data_s  = tx_data_in;
          last_s  = tx_last_in;
        end else if (count_inc_s == T15_C) begin
          state_s = S_QUIET;
          count_s = ZERO_C;
          err_s   = 1'b1;
        end else begin
          state_s = S_NEXT;
          count_s = count_inc_s;
        end
      end
      default: begin
        state_s = S_QUIET;
        count_s = ZERO_C;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    tx_ready_out     = 1'b0;
    uart_tx_en_out   = 1'b0;
    rs485_de_out     = 1'b0;
    uart_tx_data_out = data_r;
    frame_done_out   = done_r;
    frame_err_out    = err_r;
    case (state_r)
      S_QUIET: begin
        tx_ready_out = 1'b0;
      end
      S_IDLE: begin
        tx_ready_out = ~rx_done_in;
      end
      S_LOAD: begin
        uart_tx_en_out = 1'b1;
        rs485_de_out   = 1'b1;
      end
      S_BYTE_WAIT: begin
        rs485_de_out = 1'b1;
      end
      S_NEXT: begin
        tx_ready_out = 1'b1;
        rs485_de_out = 1'b1;
      end
      default: begin
        tx_ready_out = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_modbus_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_modbus_tx_framer
//   Directed sequence with randomized bytes, frame lengths, UART latencies,
//   inter-byte gaps, bus echoes and stray UART done pulses. Expected timing is
//   derived from the 3.5 / 1.5 character-time rules; transmitted bytes are
//   checked against a queue of offered bytes.
// -----------------------------------------------------------------------------
module tb_modbus_tx_framer;

  localparam int CF  = 1000000;
  localparam int BR  = 9600;
  localparam int BR2 = 38400;

  // Character-time rules: 3.5 / 1.5 chars of 11 bits, fixed above 19200 baud.
  localparam int T35   = int'((64'(CF) * 64'd385) / (64'd10 * 64'(BR)));
  localparam int T15   = int'((64'(CF) * 64'd165) / (64'd10 * 64'(BR)));
  localparam int T35_2 = int'((64'(CF) * 64'd1750) / 64'd1000000);
  localparam int T15_2 = int'((64'(CF) * 64'd750) / 64'd1000000);

  logic       clk;
  logic       rst, tx_valid, tx_last, tx_ready, rx_done, u_en, u_done, de, f_done, f_err;
  logic [7:0] tx_data, u_data;
  logic       rst2, tx_valid2, tx_last2, tx_ready2, rx_done2, u_en2, u_done2, de2, f_done2, f_err2;
  logic [7:0] tx_data2, u_data2;

  int vectors;
  int miscompares;
  logic [7:0] exp_q[$];

  modbus_tx_framer #(.CLK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk_in(clk), .rst_in(rst), .tx_data_in(tx_data), .tx_valid_in(tx_valid),
    .tx_last_in(tx_last), .tx_ready_out(tx_ready), .rx_done_in(rx_done),
    .uart_tx_data_out(u_data), .uart_tx_en_out(u_en), .uart_tx_done_in(u_done),
    .rs485_de_out(de), .frame_done_out(f_done), .frame_err_out(f_err)
  );

  modbus_tx_framer #(.CLK_FREQ(CF), .BAUD_RATE(BR2)) dut2 (
    .clk_in(clk), .rst_in(rst2), .tx_data_in(tx_data2), .tx_valid_in(tx_valid2),
    .tx_last_in(tx_last2), .tx_ready_out(tx_ready2), .rx_done_in(rx_done2),
    .uart_tx_data_out(u_data2), .uart_tx_en_out(u_en2), .uart_tx_done_in(u_done2),
    .rs485_de_out(de2), .frame_done_out(f_done2), .frame_err_out(f_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect n silent cycles (no ready, no driver) followed by ready.
  task automatic wait_quiet(input int n);
    for (int k = 0; k < n; k++) begin
      chk("quiet_ready", tx_ready, 1'b0);
      chk("quiet_de", de, 1'b0);
      chk("quiet_en", u_en, 1'b0);
      if (k > 0) begin
        chk("quiet_done", f_done, 1'b0);
        chk("quiet_err", f_err, 1'b0);
      end
      u_done = ($urandom_range(0, 63) == 0);
      tick();
    end
    u_done = 1'b0;
    chk("quiet_end_ready", tx_ready, 1'b1);
    chk("quiet_end_de", de, 1'b0);
  endtask

  // Offer one byte (after gap cycles in NEXT unless first) and complete it
  // with a UART done pulse dly cycles after the start pulse.
  task automatic send_byte(input logic [7:0] b, input logic last, input int gap,
                           input int dly, input logic first);
    logic [7:0] e;
    if (!first) begin
      for (int k = 0; k < gap; k++) begin
        chk("next_ready", tx_ready, 1'b1);
        chk("next_de", de, 1'b1);
        tick();
      end
    end
    tx_valid = 1'b1;
    tx_data  = b;
    tx_last  = last;
    exp_q.push_back(b);
    chk("hs_ready", tx_ready, 1'b1);
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom_range(0, 255));
    tx_last  = 1'($urandom_range(0, 1));
    e = exp_q.pop_front();
    chk("tx_en", u_en, 1'b1);
    chk("tx_data", u_data, e);
    chk("load_de", de, 1'b1);
    chk("load_ready", tx_ready, 1'b0);
    for (int j = 1; j < dly; j++) begin
      tick();
      rx_done = ($urandom_range(0, 7) == 0);
      chk("wait_en", u_en, 1'b0);
      chk("wait_de", de, 1'b1);
      chk("wait_ready", tx_ready, 1'b0);
      chk("wait_data_hold", u_data, e);
    end
    tick();
    rx_done = 1'b0;
    u_done  = 1'b1;
    chk("done_cycle_de", de, 1'b1);
    tick();
    u_done = 1'b0;
    chk("after_err", f_err, 1'b0);
    chk("after_en", u_en, 1'b0);
    if (last) begin
      chk("frame_done", f_done, 1'b1);
      chk("end_de", de, 1'b0);
      chk("end_ready", tx_ready, 1'b0);
      chk("end_data_hold", u_data, e);
    end else begin
      chk("mid_done", f_done, 1'b0);
      chk("mid_de", de, 1'b1);
      chk("mid_ready", tx_ready, 1'b1);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'd0; rx_done = 1'b0; u_done = 1'b0;
    rst2 = 1'b1; tx_valid2 = 1'b0; tx_last2 = 1'b0; tx_data2 = 8'd0; rx_done2 = 1'b0; u_done2 = 1'b0;
    tick();
    tick();

    // Fast-baud instance: fixed 1750 / 750 cycle gaps.
    rst2 = 1'b0;
    tx_valid2 = 1'b1;
    tx_data2 = 8'h5A;
    for (int k = 0; k < T35_2; k++) begin
      chk("b38k_quiet_ready", tx_ready2, 1'b0);
      tick();
    end
    chk("b38k_ready", tx_ready2, 1'b1);
    tick();
    tx_valid2 = 1'b0;
    chk("b38k_en", u_en2, 1'b1);
    chk("b38k_data", u_data2, 8'h5A);
    chk("b38k_de", de2, 1'b1);
    repeat (7) tick();
    u_done2 = 1'b1;
    tick();
    u_done2 = 1'b0;
    for (int k = 0; k < T15_2; k++) begin
      chk("b38k_next_ready", tx_ready2, 1'b1);
      chk("b38k_next_err", f_err2, 1'b0);
      tick();
    end
    chk("b38k_err", f_err2, 1'b1);
    chk("b38k_err_de", de2, 1'b0);
    chk("b38k_err_done", f_done2, 1'b0);
    tick();
    chk("b38k_err_pulse", f_err2, 1'b0);

    // Reset release with a byte already offered: held until T35 elapsed.
    rst = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'h01;
    chk("rst_en", u_en, 1'b0);
    chk("rst_data", u_data, 8'h00);
    chk("rst_done", f_done, 1'b0);
    chk("rst_err", f_err, 1'b0);
    wait_quiet(T35);

    // Frame 01 03 00 with 50-cycle UART latency, then T35 before next ready.
    send_byte(8'h01, 1'b0, 0, 50, 1'b1);
    send_byte(8'h03, 1'b0, 0, 50, 1'b0);
    send_byte(8'h00, 1'b1, 0, 50, 1'b0);
    wait_quiet(T35);

    // Bus byte while idle beats a same-cycle offer.
    tx_valid = 1'b1;
    tx_data = 8'h77;
    rx_done = 1'b1;
    #1;
    chk("idle_rx_ready", tx_ready, 1'b0);
    tick();
    rx_done = 1'b0;
    tx_valid = 1'b0;
    chk("idle_rx_en", u_en, 1'b0);
    chk("idle_rx_ready_after", tx_ready, 1'b0);

    // Bus byte at quiet count 3000 restarts silence: ready at 3000+T35.
    for (int k = 0; k < 3000; k++) begin
      chk("rx3000_ready", tx_ready, 1'b0);
      tick();
    end
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    wait_quiet(T35 - 1);

    // Inter-character timeout after the first byte.
    send_byte(8'($urandom_range(0, 255)), 1'b0, 0, $urandom_range(1, 80), 1'b1);
    for (int k = 0; k < T15; k++) begin
      chk("to_ready", tx_ready, 1'b1);
      chk("to_de", de, 1'b1);
      chk("to_err_early", f_err, 1'b0);
      tick();
    end
    chk("to_err", f_err, 1'b1);
    chk("to_de_drop", de, 1'b0);
    chk("to_done", f_done, 1'b0);
    chk("to_en", u_en, 1'b0);
    wait_quiet(T35);

    // Reset while the UART is busy with a byte.
    tx_valid = 1'b1;
    tx_data = 8'hC3;
    tx_last = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("rb_en", u_en, 1'b1);
    chk("rb_data", u_data, 8'hC3);
    repeat (10) begin
      tick();
      chk("rb_de", de, 1'b1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_de_drop", de, 1'b0);
    chk("rb_done", f_done, 1'b0);
    chk("rb_err", f_err, 1'b0);
    chk("rb_data_clr", u_data, 8'h00);
    chk("rb_ready", tx_ready, 1'b0);
    u_done = 1'b1;
    tick();
    u_done = 1'b0;
    chk("rb_stray_done", f_done, 1'b0);
    wait_quiet(T35 - 1);

    // Random frames; the first one exercises the last legal gap cycle.
    for (int f = 0; f < 5; f++) begin
      int n;
      n = $urandom_range(1, 4);
      if (f == 0) begin
        n = 3;
      end
      for (int i = 0; i < n; i++) begin
        int gap;
        gap = (f == 0 && i == 1) ? T15 - 1 : $urandom_range(0, 300);
        send_byte(8'($urandom_range(0, 255)), (i == n - 1), gap,
                  $urandom_range(1, 80), (i == 0));
      end
      tx_valid = 1'($urandom_range(0, 1));
      tx_data = 8'($urandom_range(0, 255));
      tx_last = 1'b0;
      wait_quiet(T35);
      tx_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/modbus_tx_framer.md
MODBUS_TX_FRAMER -- requirements
Module: modbus_tx_framer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning serial line bit rate.
REQ-003 SHALL have port clk_in  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tx_data_in  input  8  frame byte offered by upstream.
REQ-006 SHALL have port tx_valid_in  input  1  tx_data_in/tx_last_in valid.
REQ-007 SHALL have port tx_last_in  input  1  offered byte is last of frame.
REQ-008 SHALL have port tx_ready_out  output  1  block accepts the offered byte; handshake = valid & ready.
REQ-009 SHALL have port rx_done_in  input  1  one-cycle pulse per byte received on the shared bus.
REQ-010 SHALL have port uart_tx_data_out  output  8  byte to UART transmitter.
REQ-011 SHALL have port uart_tx_en_out  output  1  one-cycle start pulse to UART transmitter.
REQ-012 SHALL have port uart_tx_done_in  input  1  one-cycle pulse when UART has sent the stop bit.
REQ-013 SHALL have port rs485_de_out  output  1  RS-485 driver enable.
REQ-014 SHALL have port frame_done_out  output  1  one-cycle pulse, frame sent completely.
REQ-015 SHALL have port frame_err_out  output  1  one-cycle pulse, frame aborted on inter-character timeout.

Function
REQ-016 SHALL derive T35 = BAUD_RATE>19200 ? CLK_FREQ*1750/1000000 : CLK_FREQ*385/(10*BAUD_RATE) cycles, integer truncation.
REQ-017 SHALL derive T15 = BAUD_RATE>19200 ? CLK_FREQ*750/1000000 : CLK_FREQ*165/(10*BAUD_RATE) cycles, integer truncation.
REQ-018 SHALL size the single shared counter to $clog2(T35+1) bits; it saturates at T35 and never wraps.
REQ-019 SHALL implement states QUIET (counting silence), IDLE (gap met), LOAD, BYTE_WAIT, NEXT.
REQ-020 QUIET: counter increments each cycle; rx_done_in clears it to 0 that cycle; on count==T35 go IDLE.
REQ-021 IDLE: tx_ready_out=1; rx_done_in returns to QUIET with counter 0, with priority over a same-cycle handshake (byte not accepted).
REQ-022 On handshake in IDLE or NEXT: register data and last flag, go LOAD; next cycle uart_tx_en_out=1 with registered data and rs485_de_out=1.
REQ-023 LOAD lasts one cycle, then BYTE_WAIT; tx_ready_out=0 in LOAD and BYTE_WAIT.
REQ-024 BYTE_WAIT: on uart_tx_done_in, if last flag set go QUIET, counter 0, rs485_de_out=0 and frame_done_out=1 in the following cycle; else go NEXT, counter 0.
REQ-025 NEXT: tx_ready_out=1, counter increments; if no handshake by count==T15, pulse frame_err_out, drop rs485_de_out, go QUIET with counter 0.
REQ-026 rs485_de_out SHALL stay 1 from first uart_tx_en_out through the frame's last uart_tx_done_in or abort, with no gaps.
REQ-027 rx_done_in SHALL be ignored in LOAD, BYTE_WAIT, NEXT (own echo).
REQ-028 uart_tx_done_in outside BYTE_WAIT SHALL be ignored.
REQ-029 tx_valid_in without ready SHALL not be consumed; upstream holds the byte.
REQ-030 frame_done_out and frame_err_out SHALL never assert in the same cycle.
REQ-031 uart_tx_data_out SHALL hold its value until the next LOAD.

Reset
REQ-032 rst_in=1 SHALL force state QUIET, counter 0, registered data 0; all outputs 0 the next cycle.
REQ-033 Reset mid-frame SHALL drop rs485_de_out next cycle without a frame_done_out or frame_err_out pulse.
REQ-034 After reset release a full T35 of silence SHALL elapse before tx_ready_out asserts.

Verification (CLK_FREQ=1000000, BAUD_RATE=9600: T35=4010, T15=1718)
REQ-035 Reset release, tx_valid_in=1 data 0x01 -> tx_ready_out 0 for cycles 0..4009, 1 at cycle 4010; next cycle uart_tx_en_out=1, data 0x01, rs485_de_out=1.
REQ-036 Frame 0x01,0x03,0x00 (last on 0x00), done pulses 50 cycles after each tx_en -> three tx_en pulses, de continuous, frame_done_out once the cycle after third done; next ready 4010 cycles later.
REQ-037 rx_done_in at quiet count 3000 -> ready at 3000+4010 cycles, not 4010.
REQ-038 After first byte done, tx_valid_in held low -> frame_err_out pulse at count 1718, de=0, no further tx_en.
REQ-039 rst_in pulse in BYTE_WAIT -> de=0 next cycle, no done/err pulse, ready again only after 4010 quiet cycles.
REQ-040 BAUD_RATE=38400 -> ready 1750 cycles after reset; inter-character timeout at 750.
